// File: rtl/i2c_pkg.sv
// Shared types and helpers for the n-byte I2C write master.
// State and quarter-phase encodings, divider math, bit-counter width.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } qphase_t;

    localparam int BIT_CNT_W = 3;

    // System clocks per quarter of an SCL period.
    function automatic int qdiv_f(input int clk_hz, input int scl_hz);
        return clk_hz / (4 * scl_hz);
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider for the I2C master.
// Counts 0..QDIV-1 while enabled; hold parks the count at 0.
module i2c_tick_gen #(
    parameter int QDIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_hold,
    output logic o_tick
);

    localparam int CW = $clog2(QDIV);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(QDIV - 1));
    assign o_tick = i_en && !i_hold && w_wrap;

    // Free-running quarter counter, cleared when idle or held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || i_hold) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_nbyte.sv
// Open-drain I2C write master: START, 1..MAX_BYTES bytes with ACK, STOP.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching on SCL.
module i2c_master_nbyte
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int I2C_FREQ  = 100_000,
    parameter int MAX_BYTES = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(MAX_BYTES+1)-1:0] num_bytes,
    input  logic [8*MAX_BYTES-1:0]         tx_data,
    output logic                           busy,
    output logic                           done,
    output logic                           ack_n,
    output logic [$clog2(MAX_BYTES)-1:0]   nack_idx,
    inout  wire                            i2c_sdata,
    inout  wire                            i2c_sclk
);

    localparam int QDIV = qdiv_f(CLK_FREQ, I2C_FREQ);
    localparam int NB_W = $clog2(MAX_BYTES + 1);
    localparam int IX_W = $clog2(MAX_BYTES);
    localparam int SR_W = 8 * MAX_BYTES;

    state_t               r_state;
    state_t               w_state_nxt;
    qphase_t              r_q;
    qphase_t              w_q_nxt;
    qphase_t              w_q_inc;
    logic [BIT_CNT_W-1:0] r_bit;
    logic [BIT_CNT_W-1:0] w_bit_nxt;
    logic [IX_W-1:0]      r_idx;
    logic [IX_W-1:0]      w_idx_nxt;
    logic [IX_W-1:0]      r_last;
    logic [SR_W-1:0]      r_shift;
    logic [SR_W-1:0]      w_shift_nxt;
    logic [NB_W-1:0]      w_nb;
    logic                 w_load;
    logic                 w_nack;
    logic                 w_tick;
    logic                 w_hold;
    logic                 r_ack_n;
    logic [IX_W-1:0]      r_nack_idx;
    logic                 r_sda_lo;
    logic                 r_scl_lo;
    logic                 w_sda_lo_nxt;
    logic                 w_scl_lo_nxt;
    logic [1:0]           r_sda_sync;
    logic                 w_sda_s;

    assign w_nb    = (num_bytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : num_bytes;
    assign w_q_inc = qphase_t'(r_q + 2'd1);
    assign w_sda_s = r_sda_sync[1];

    assign ack_n    = r_ack_n;
    assign nack_idx = r_nack_idx;

    assign i2c_sdata = r_sda_lo ? 1'b0 : 1'bz;
    assign i2c_sclk  = r_scl_lo ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] r_scl_sync;

    // Bring the shared SCL line into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i2c_sclk};
        end
    end

    assign w_hold = (r_state == ST_BIT || r_state == ST_ACK || r_state == ST_STOP)
                    && (r_q == Q2) && !r_scl_sync[1];
`else
    assign w_hold = 1'b0;
`endif

    i2c_tick_gen #(
        .QDIV(QDIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (busy),
        .i_hold(w_hold),
        .o_tick(w_tick)
    );

    // FSM state plus bit/byte counters and the transmit shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_q     <= Q0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_bit   <= w_bit_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next state: advance one quarter per tick, walk bits and bytes.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_bit_nxt   = r_bit;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_nack      = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (start) begin
                    w_load      = 1'b1;
                    w_q_nxt     = Q0;
                    w_bit_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_shift_nxt = tx_data;
                    w_state_nxt = (w_nb == '0) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_q_nxt = w_q_inc;
                    if (r_q == Q3) begin
                        w_state_nxt = ST_BIT;
                    end
                end
            end
            ST_BIT: begin
                if (w_tick) begin
                    w_q_nxt = w_q_inc;
                    if (r_q == Q3) begin
                        w_shift_nxt = {r_shift[SR_W-2:0], 1'b0};
                        if (r_bit == BIT_CNT_W'(7)) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = ST_ACK;
                        end else begin
                            w_bit_nxt = r_bit + BIT_CNT_W'(1);
                        end
                    end
                end
            end
            ST_ACK: begin
                if (w_tick) begin
                    w_q_nxt = w_q_inc;
                    if (r_q == Q3) begin
                        if (w_sda_s) begin
                            w_nack      = 1'b1;
                            w_state_nxt = ST_STOP;
                        end else if (r_idx == r_last) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_idx_nxt   = r_idx + IX_W'(1);
                            w_state_nxt = ST_BIT;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_q_nxt = w_q_inc;
                    if (r_q == Q3) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status and line levels for the state being entered.
    always_comb begin
        busy         = (r_state == ST_START) || (r_state == ST_BIT)
                    || (r_state == ST_ACK)   || (r_state == ST_STOP);
        done         = (r_state == ST_DONE);
        w_sda_lo_nxt = 1'b0;
        w_scl_lo_nxt = 1'b0;
        unique case (w_state_nxt)
            ST_START: begin
                w_sda_lo_nxt = (w_q_nxt == Q2) || (w_q_nxt == Q3);
            end
            ST_BIT: begin
                w_scl_lo_nxt = (w_q_nxt == Q0) || (w_q_nxt == Q1);
                w_sda_lo_nxt = ~w_shift_nxt[SR_W-1];
            end
            ST_ACK: begin
                w_scl_lo_nxt = (w_q_nxt == Q0) || (w_q_nxt == Q1);
            end
            ST_STOP: begin
                w_scl_lo_nxt = (w_q_nxt == Q0) || (w_q_nxt == Q1);
                w_sda_lo_nxt = (w_q_nxt != Q3);
            end
            default: begin
                w_sda_lo_nxt = 1'b0;
                w_scl_lo_nxt = 1'b0;
            end
        endcase
    end

    // Open-drain pull-down enables, changed only on state/quarter moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_lo <= 1'b0;
            r_scl_lo <= 1'b0;
        end else begin
            r_sda_lo <= w_sda_lo_nxt;
            r_scl_lo <= w_scl_lo_nxt;
        end
    end

    // Synchronise SDA for the acknowledge sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_sync <= 2'b11;
        end else begin
            r_sda_sync <= {r_sda_sync[0], i2c_sdata};
        end
    end

    // Transaction result: cleared on accept, set on a NACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= '0;
            r_ack_n    <= 1'b0;
            r_nack_idx <= '0;
        end else if (w_load) begin
            r_last     <= IX_W'(w_nb - NB_W'(1));
            r_ack_n    <= 1'b0;
            r_nack_idx <= '0;
        end else if (w_nack) begin
            r_ack_n    <= 1'b1;
            r_nack_idx <= r_idx;
        end
    end

endmodule
